serial_load_ctrl: RTL and testbench

SERIAL_LOAD_CTRL -- requirements
Module: serial_load_ctrl

---
 rtl/serial_load_ctrl.sv | 115 +++++++++++
 tb/tb_serial_load_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_load_ctrl.sv
// Serial-to-parallel frame loader for a downstream counter's parallel load port.
// Define SERIAL_PARITY_CHECK_EN to add a 9th even-parity bit with an err pulse on mismatch.
module serial_load_ctrl #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sdata,
  input  logic       abort,
  output logic [7:0] data_out,
  output logic       load,
  output logic       busy,
  output logic       err
);

`ifdef SERIAL_PARITY_CHECK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    LOAD   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd3
  } state_t;
`endif

  state_t     state_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic [7:0] data_out_reg;
  logic       load_reg;
  logic       err_reg;

  // Serial input always lands in the end the first bit walks away from.
  always_comb begin
    shift_next = shift_reg;
    if (MSB_FIRST)
      shift_next = {shift_reg[6:0], sdata};
    else
      shift_next = {sdata, shift_reg[7:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      data_out_reg <= 8'h00;
      load_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      load_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
          end
        end
        SHIFT: begin
          // Abort wins over completing the last sample on the same edge.
          if (abort) begin
            state_reg <= IDLE;
          end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
`ifdef SERIAL_PARITY_CHECK_EN
              state_reg <= PARITY;
`else
              state_reg    <= LOAD;
              data_out_reg <= shift_next;
              load_reg     <= 1'b1;
`endif
            end
          end
        end
`ifdef SERIAL_PARITY_CHECK_EN
        PARITY: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if ((^shift_reg) == sdata) begin
            state_reg    <= LOAD;
            data_out_reg <= shift_reg;
            load_reg     <= 1'b1;
          end else begin
            state_reg <= IDLE;
            err_reg   <= 1'b1;
          end
        end
`endif
        LOAD: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign data_out = data_out_reg;
  assign load     = load_reg;
  assign err      = err_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Bench for serial_load_ctrl: both bit orders side by side, table vectors, corner sequences, random frames.
// Frame length follows SERIAL_PARITY_CHECK_EN.
module tb_serial_load_ctrl;

`ifdef SERIAL_PARITY_CHECK_EN
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif
  localparam int PERIOD = FRAME_BITS + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sdata;
  logic       abort;
  logic [7:0] data_m, data_l;
  logic       load_m, load_l, busy_m, busy_l, err_m, err_l;

  int n_cmp  = 0;
  int n_fail = 0;
  bit both_seen = 1'b0;
  logic [7:0] prev_m = 8'h00;
  logic [7:0] prev_l = 8'h00;

  serial_load_ctrl #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .start(start), .sdata(sdata), .abort(abort),
    .data_out(data_m), .load(load_m), .busy(busy_m), .err(err_m)
  );

  serial_load_ctrl #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .start(start), .sdata(sdata), .abort(abort),
    .data_out(data_l), .load(load_l), .busy(busy_l), .err(err_l)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((load_m && err_m) || (load_l && err_l))
      both_seen = 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // First bit sent is seq[7]; MSB-first places it at the top, LSB-first at the bottom.
  function automatic logic [7:0] model_msb(input logic [7:0] seq);
    int v = 0;
    for (int k = 0; k < 8; k++) v = v * 2 + int'(seq[7-k]);
    return v[7:0];
  endfunction

  function automatic logic [7:0] model_lsb(input logic [7:0] seq);
    int v = 0;
    for (int k = 0; k < 8; k++) v = v + (int'(seq[7-k]) << k);
    return v[7:0];
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] seq, input int abort_k,
                           input bit par_ok, input bit hold_start,
                           input logic [7:0] exp_m, input logic [7:0] exp_l);
    logic pbit;
    bit   bad_par;
    pbit = (^seq) ^ !par_ok;
`ifdef SERIAL_PARITY_CHECK_EN
    bad_par = !par_ok;
`else
    bad_par = 1'b0;
`endif
    start = 1'b1;
    abort = 1'b0;
    sdata = 1'($urandom);
    @(posedge clk); #1;
    chk({tag, " busy_accept_m"}, {7'b0, busy_m}, 8'd1);
    chk({tag, " busy_accept_l"}, {7'b0, busy_l}, 8'd1);
    start = hold_start;
    for (int k = 0; k < FRAME_BITS; k++) begin
      sdata = (k < 8) ? seq[7-k] : pbit;
      abort = (k == abort_k);
      @(posedge clk); #1;
      if (k == abort_k) begin
        abort = 1'b0;
        start = 1'b0;
        chk({tag, " abort_busy"}, {7'b0, busy_m | busy_l}, 8'd0);
        chk({tag, " abort_load"}, {7'b0, load_m | load_l}, 8'd0);
        chk({tag, " abort_err"},  {7'b0, err_m | err_l}, 8'd0);
        chk({tag, " abort_data_m"}, data_m, prev_m);
        chk({tag, " abort_data_l"}, data_l, prev_l);
        return;
      end
      if (k < FRAME_BITS - 1) begin
        chk({tag, " mid_busy"}, {7'b0, busy_m & busy_l}, 8'd1);
        chk({tag, " mid_load"}, {7'b0, load_m | load_l}, 8'd0);
      end
    end
    start = 1'b0;
    abort = 1'($urandom);
    sdata = 1'($urandom);
    if (bad_par) begin
      chk({tag, " perr_err_m"}, {7'b0, err_m}, 8'd1);
      chk({tag, " perr_err_l"}, {7'b0, err_l}, 8'd1);
      chk({tag, " perr_load"}, {7'b0, load_m | load_l}, 8'd0);
      chk({tag, " perr_busy"}, {7'b0, busy_m | busy_l}, 8'd0);
      chk({tag, " perr_data_m"}, data_m, prev_m);
      chk({tag, " perr_data_l"}, data_l, prev_l);
      @(posedge clk); #1;
      abort = 1'b0;
      chk({tag, " perr_err_clear"}, {7'b0, err_m | err_l}, 8'd0);
    end else begin
      chk({tag, " load_m"}, {7'b0, load_m}, 8'd1);
      chk({tag, " load_l"}, {7'b0, load_l}, 8'd1);
      chk({tag, " err_at_load"}, {7'b0, err_m | err_l}, 8'd0);
      chk({tag, " busy_in_load"}, {7'b0, busy_m & busy_l}, 8'd1);
      chk({tag, " data_m"}, data_m, exp_m);
      chk({tag, " data_l"}, data_l, exp_l);
      prev_m = exp_m;
      prev_l = exp_l;
      @(posedge clk); #1;
      abort = 1'b0;
      chk({tag, " load_pulse_end"}, {7'b0, load_m | load_l}, 8'd0);
      chk({tag, " busy_after_load"}, {7'b0, busy_m | busy_l}, 8'd0);
      chk({tag, " data_hold_m"}, data_m, exp_m);
    end
  endtask

  typedef struct {
    logic [7:0] seq;
    int         abort_k;
    bit         par_ok;
    bit         hold_start;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'b10100101, -1, 1'b1, 1'b0, 8'hA5, 8'hA5};
    tbl[1] = '{8'b11000000, -1, 1'b1, 1'b0, 8'hC0, 8'h03};
    tbl[2] = '{8'b01011010, -1, 1'b0, 1'b0, 8'h5A, 8'h5A};
    tbl[3] = '{8'b01011010, -1, 1'b1, 1'b0, 8'h5A, 8'h5A};
    tbl[4] = '{8'b11110000,  3, 1'b1, 1'b1, 8'h00, 8'h00};
    tbl[5] = '{8'b00000001, -1, 1'b1, 1'b1, 8'h01, 8'h80};
    tbl[6] = '{8'b11111111,  7, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[7] = '{8'b10000000, -1, 1'b1, 1'b0, 8'h80, 8'h01};

    reset = 1'b1;
    start = 1'b0;
    sdata = 1'b0;
    abort = 1'b0;
    #2;
    chk("reset_data_m", data_m, 8'h00);
    chk("reset_data_l", data_l, 8'h00);
    chk("reset_ctl", {4'b0, load_m | load_l, busy_m | busy_l, err_m | err_l, 1'b0}, 8'h00);
    #10;
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_frame($sformatf("vec%0d", i), tbl[i].seq, tbl[i].abort_k, tbl[i].par_ok,
                tbl[i].hold_start, tbl[i].exp_m, tbl[i].exp_l);
    $display("table vectors done: %0d compared so far", n_cmp);

    // Asynchronous reset mid-frame.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sdata = 1'($urandom);
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_data_m", data_m, 8'h00);
    chk("midreset_data_l", data_l, 8'h00);
    chk("midreset_ctl", {5'b0, load_m | load_l, busy_m | busy_l, err_m | err_l}, 8'h00);
    #2;
    reset = 1'b0;
    prev_m = 8'h00;
    prev_l = 8'h00;
    begin
      int loads = 0;
      for (int c = 0; c < 12; c++) begin
        sdata = 1'($urandom);
        @(posedge clk); #1;
        if (load_m || load_l || busy_m || busy_l) loads++;
      end
      chk("midreset_no_load", loads[7:0], 8'd0);
    end
    $display("mid-frame reset sequence done");

    // Start held high: one load per PERIOD cycles.
    begin
      int loads = 0;
      int bad_pos = 0;
      int waited = 0;
      start = 1'b1;
      for (int c = 0; c < 4 * PERIOD; c++) begin
        sdata = 1'($urandom);
        @(posedge clk); #1;
        if (load_m !== load_l) bad_pos++;
        if (load_m) begin
          loads++;
          if ((c % PERIOD) != PERIOD - 2) bad_pos++;
        end
      end
      start = 1'b0;
      chk("b2b_load_count", loads[7:0], 8'd4);
      chk("b2b_load_spacing", bad_pos[7:0], 8'd0);
      while (busy_m && waited < 3 * PERIOD) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("b2b_drain_idle", {7'b0, busy_m | busy_l}, 8'd0);
      prev_m = data_m;
      prev_l = data_l;
      $display("back-to-back sequence done: %0d loads", loads);
    end

    // Random frames with idle gaps, checked against the arithmetic model.
    for (int f = 0; f < 40; f++) begin
      logic [7:0] seq;
      int ak;
      int gap;
      seq = 8'($urandom);
      ak  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME_BITS - 1)) : -1;
      run_frame($sformatf("rnd%0d", f), seq, ak, ($urandom_range(0, 2) != 0),
                1'($urandom), model_msb(seq), model_lsb(seq));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        sdata = 1'($urandom);
        abort = 1'($urandom);
        @(posedge clk); #1;
        chk("idle_gap_quiet", {6'b0, busy_m | busy_l, load_m | load_l}, 8'd0);
      end
      abort = 1'b0;
    end
    $display("random frames done");

    chk("load_err_exclusive", {7'b0, both_seen}, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
